rf_wb_arb: RTL and testbench

RF_WB_ARB -- requirements
Module: rf_wb_arb

---
 rtl/rf_wb_arb.sv | 135 +++++++++++++
 tb/tb_rf_wb_arb.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arb.sv
// Writeback arbiter: round-robin grant among three writeback sources into one
// registered regfile write port, plus per-register pending-write scoreboard.
module rf_wb_arb (
    input  logic        clk,
    input  logic        resetn,
    input  logic        wb0_valid,
    input  logic [4:0]  wb0_addr,
    input  logic [31:0] wb0_data,
    output logic        wb0_ready,
    input  logic        wb1_valid,
    input  logic [4:0]  wb1_addr,
    input  logic [31:0] wb1_data,
    output logic        wb1_ready,
    input  logic        wb2_valid,
    input  logic [4:0]  wb2_addr,
    input  logic [31:0] wb2_data,
    output logic        wb2_ready,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    input  logic        alloc_valid,
    input  logic [4:0]  alloc_addr,
    output logic        alloc_ready,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic        rs1_busy,
    output logic        rs2_busy
);

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // ready never depends on ready, and a source must hold valid until granted.

    logic [1:0]  ptr;
    logic [1:0]  ptr_nxt;
    logic [2:0]  valid;
    logic [2:0]  grant;
    logic        xfer;
    logic [4:0]  sel_addr;
    logic [31:0] sel_data;
    logic        alloc_fire;
    logic [1:0]  cnt     [32];
    logic [1:0]  cnt_nxt [32];

    assign valid = {wb2_valid, wb1_valid, wb0_valid};

    // Rotating priority starting at ptr; reset forces every grant low.
    always_comb begin
        grant = 3'b000;
        if (resetn) begin
            case (ptr)
                2'd1: begin
                    if (valid[1])      grant = 3'b010;
                    else if (valid[2]) grant = 3'b100;
                    else if (valid[0]) grant = 3'b001;
                end
                2'd2: begin
                    if (valid[2])      grant = 3'b100;
                    else if (valid[0]) grant = 3'b001;
                    else if (valid[1]) grant = 3'b010;
                end
                default: begin
                    if (valid[0])      grant = 3'b001;
                    else if (valid[1]) grant = 3'b010;
                    else if (valid[2]) grant = 3'b100;
                end
            endcase
        end
    end

    assign wb0_ready = grant[0];
    assign wb1_ready = grant[1];
    assign wb2_ready = grant[2];
    assign xfer      = |grant;

    always_comb begin
        sel_addr = wb0_addr;
        sel_data = wb0_data;
        ptr_nxt  = ptr;
        if (grant[0]) ptr_nxt = 2'd1;
        if (grant[1]) begin
            sel_addr = wb1_addr;
            sel_data = wb1_data;
            ptr_nxt  = 2'd2;
        end
        if (grant[2]) begin
            sel_addr = wb2_addr;
            sel_data = wb2_data;
            ptr_nxt  = 2'd0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ptr      <= 2'd0;
            rf_we    <= 1'b0;
            rf_waddr <= 5'd0;
            rf_wdata <= 32'd0;
        end else begin
            ptr   <= ptr_nxt;
            rf_we <= xfer && (sel_addr != 5'd0);
            // Writes to r0 are swallowed and leave the last address/data intact.
            if (xfer && (sel_addr != 5'd0)) begin
                rf_waddr <= sel_addr;
                rf_wdata <= sel_data;
            end
        end
    end

    assign alloc_ready = resetn && (cnt[alloc_addr] != 2'd3);
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign rs1_busy    = (cnt[rs1_addr] != 2'd0);
    assign rs2_busy    = (cnt[rs2_addr] != 2'd0);

    // An increment and a decrement of the same register cancel out.
    always_comb begin
        cnt_nxt[0] = 2'd0;
        for (int r = 1; r < 32; r++) begin
            cnt_nxt[r] = cnt[r];
            if (alloc_fire && (alloc_addr == 5'(r)) && !(rf_we && (rf_waddr == 5'(r))))
                cnt_nxt[r] = cnt[r] + 2'd1;
            else if (rf_we && (rf_waddr == 5'(r)) && !(alloc_fire && (alloc_addr == 5'(r)))
                     && (cnt[r] != 2'd0))
                cnt_nxt[r] = cnt[r] - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int r = 0; r < 32; r++) cnt[r] <= 2'd0;
        end else begin
            for (int r = 0; r < 32; r++) cnt[r] <= cnt_nxt[r];
        end
    end

endmodule

// File: tb/tb_rf_wb_arb.sv
// Bench for rf_wb_arb: directed scenarios then random traffic, all checked
// against a transaction-level model of grants, regfile writes and pending counts.
module tb_rf_wb_arb;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [2:0]  v = '0;
    logic [2:0][4:0]  a = '0;
    logic [2:0][31:0] d = '0;
    logic        wb0_ready, wb1_ready, wb2_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        alloc_valid = 1'b0;
    logic [4:0]  alloc_addr = '0;
    logic        alloc_ready;
    logic [4:0]  rs1_addr = '0, rs2_addr = '0;
    logic        rs1_busy, rs2_busy;

    int compared = 0;
    int failed = 0;

    // Reference model state
    int          ptr_m;
    int          cnt_m [32];
    bit          we_m;
    logic [4:0]  waddr_m;
    logic [31:0] wdata_m;
    int          last_g;

    rf_wb_arb dut (
        .clk(clk), .resetn(resetn),
        .wb0_valid(v[0]), .wb0_addr(a[0]), .wb0_data(d[0]), .wb0_ready(wb0_ready),
        .wb1_valid(v[1]), .wb1_addr(a[1]), .wb1_data(d[1]), .wb1_ready(wb1_ready),
        .wb2_valid(v[2]), .wb2_addr(a[2]), .wb2_data(d[2]), .wb2_ready(wb2_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .alloc_valid(alloc_valid), .alloc_addr(alloc_addr), .alloc_ready(alloc_ready),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        ptr_m = 0;
        for (int r = 0; r < 32; r++) cnt_m[r] = 0;
        we_m = 0;
        waddr_m = '0;
        wdata_m = '0;
        last_g = -1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'({wb2_ready, wb1_ready, wb0_ready}), 32'd0);
        chk({tag, "_alloc_ready"}, 32'(alloc_ready), 32'd0);
        chk({tag, "_rf_we"}, 32'(rf_we), 32'd0);
        chk({tag, "_rf_waddr"}, 32'(rf_waddr), 32'd0);
        chk({tag, "_rf_wdata"}, rf_wdata, 32'd0);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        #1;
        chk_reset_outputs("reset");
        resetn = 1'b1;
    endtask

    // One cycle: inputs already driven; check outputs before the edge, then
    // advance the model across the edge.
    task automatic step(input string tag);
        int g;
        bit ardy;
        int inc_r, dec_r;
        #1;
        g = -1;
        for (int k = 0; k < 3; k++)
            if (g < 0 && v[(ptr_m + k) % 3]) g = (ptr_m + k) % 3;
        ardy = (cnt_m[alloc_addr] < 3);
        chk({tag, "_wb_ready"}, 32'({wb2_ready, wb1_ready, wb0_ready}),
            (g >= 0) ? (32'd1 << g) : 32'd0);
        chk({tag, "_alloc_ready"}, 32'(alloc_ready), 32'(ardy));
        chk({tag, "_rs1_busy"}, 32'(rs1_busy), 32'(cnt_m[rs1_addr] != 0));
        chk({tag, "_rs2_busy"}, 32'(rs2_busy), 32'(cnt_m[rs2_addr] != 0));
        chk({tag, "_rf_we"}, 32'(rf_we), 32'(we_m));
        chk({tag, "_rf_waddr"}, 32'(rf_waddr), 32'(waddr_m));
        chk({tag, "_rf_wdata"}, rf_wdata, wdata_m);
        @(posedge clk);
        inc_r = (alloc_valid && ardy && alloc_addr != 0) ? int'(alloc_addr) : -1;
        dec_r = we_m ? int'(waddr_m) : -1;
        if (inc_r != dec_r) begin
            if (inc_r > 0) cnt_m[inc_r]++;
            if (dec_r > 0 && cnt_m[dec_r] > 0) cnt_m[dec_r]--;
        end
        we_m = 0;
        if (g >= 0) begin
            if (a[g] != 0) begin
                we_m = 1;
                waddr_m = a[g];
                wdata_m = d[g];
            end
            ptr_m = (g + 1) % 3;
        end
        last_g = g;
        @(negedge clk);
    endtask

    initial begin
        model_clear();
        // Reset with all sources requesting: nothing may be granted.
        v = 3'b111;
        alloc_valid = 1'b1;
        a[0] = 5'd1; a[1] = 5'd2; a[2] = 5'd3;
        d[0] = 32'h1111_0001; d[1] = 32'h2222_0002; d[2] = 32'h3333_0003;
        do_reset();
        alloc_valid = 1'b0;

        // All three requesting continuously: round-robin 0,1,2,0.
        repeat (5) step("rr");
        v = 3'b000;
        step("rr_idle");

        // Only wb2 with a distinctive payload.
        v = 3'b100; a[2] = 5'd5; d[2] = 32'hDEAD_BEEF;
        step("wb2_only");
        v = 3'b000;
        step("wb2_write");
        chk("ptr_after_wb2_grant_src0", 32'(wb0_ready), 32'd0);

        // Fill r7 to saturation, then drain one.
        rs1_addr = 5'd7;
        alloc_valid = 1'b1; alloc_addr = 5'd7;
        repeat (4) step("alloc7");
        alloc_valid = 1'b0;
        v = 3'b001; a[0] = 5'd7; d[0] = 32'h0000_0777;
        step("wr7_grant");
        v = 3'b000;
        step("wr7_commit");
        step("wr7_after");
        chk("cnt7_busy", 32'(rs1_busy), 32'd1);

        // Simultaneous alloc and write to r4 cancel.
        rs2_addr = 5'd4;
        alloc_valid = 1'b1; alloc_addr = 5'd4;
        step("alloc4");
        alloc_valid = 1'b0;
        v = 3'b010; a[1] = 5'd4; d[1] = 32'h0000_0444;
        step("wr4_grant");
        v = 3'b000;
        alloc_valid = 1'b1;
        step("wr4_and_alloc");
        alloc_valid = 1'b0;
        v = 3'b100; a[2] = 5'd4; d[2] = 32'h0000_4444;
        step("wr4b_grant");
        v = 3'b000;
        step("wr4b_commit");
        step("wr4b_after");
        chk("cnt4_idle", 32'(rs2_busy), 32'd0);

        // Address zero on both interfaces.
        v = 3'b010; a[1] = 5'd0; d[1] = 32'hFFFF_FFFF;
        rs1_addr = 5'd0;
        step("wr0_grant");
        v = 3'b000;
        alloc_valid = 1'b1; alloc_addr = 5'd0;
        step("wr0_commit_alloc0");
        alloc_valid = 1'b0;
        step("alloc0_after");

        // Asynchronous reset in the middle of traffic.
        rs1_addr = 5'd9;
        alloc_valid = 1'b1; alloc_addr = 5'd9;
        repeat (2) step("alloc9");
        alloc_valid = 1'b0;
        v = 3'b110; a[1] = 5'd10; a[2] = 5'd11;
        step("pre_reset");
        #2 resetn = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        model_clear();
        @(negedge clk);
        resetn = 1'b1;
        v = 3'b111; a[0] = 5'd12; a[1] = 5'd13; a[2] = 5'd14;
        step("post_reset_first");
        chk("post_reset_busy9", 32'(rs1_busy), 32'd0);
        v = 3'b000;
        step("post_reset_commit");

        // Random traffic; ungranted sources hold their request.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 3; i++) begin
                if (!v[i] || last_g == i) begin
                    v[i] = ($urandom_range(0, 2) != 0);
                    a[i] = 5'($urandom_range(0, 7));
                    d[i] = $urandom;
                end
            end
            alloc_valid = 1'($urandom_range(0, 1));
            alloc_addr = 5'($urandom_range(0, 7));
            rs1_addr = 5'($urandom_range(0, 7));
            rs2_addr = 5'($urandom_range(0, 7));
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
